// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_ctrl_pkg : register map and bus constants shared by the interrupt block
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
package irq_ctrl_pkg;

  // Word offsets within the controller's register window
  localparam logic [2:0] IRQC_PEND = 3'd0;
  localparam logic [2:0] IRQC_MASK = 3'd1;
  localparam logic [2:0] IRQC_MODE = 3'd2;
  localparam logic [2:0] IRQC_VEC  = 3'd3;
  localparam logic [2:0] IRQC_SET  = 3'd4;
  localparam logic [2:0] IRQC_CTRL = 3'd5;

  localparam int          IRQC_CS_INDEX      = 11;
  localparam logic [15:0] IRQC_BASE_ADDR     = 16'hB000;
  localparam int          IRQC_VEC_VALID_BIT = 31;
  localparam int          IRQC_VEC_W         = 5;

endpackage : irq_ctrl_pkg
`default_nettype wire

// File: rtl/irq_sync_edge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_sync_edge : per-line synchroniser plus one delay flop for rising edges
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module irq_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic s,
  output logic edge_evt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   p;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      p      <= 1'b0;
    end else begin
      sync_q[0] <= irq_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      p <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign edge_evt = s & ~p;

endmodule : irq_sync_edge
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_ctrl : bus-mapped interrupt controller, fixed lowest-index priority
// Revision 1.0 : initial release
// ----------------------------------------------------------------------------
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int NIRQ        = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  wen,
  input  logic [2:0]            addr,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  input  logic [NIRQ-1:0]       irq_in,
  input  logic                  irq_ack,
  output logic                  irq,
  output logic [IRQC_VEC_W-1:0] irq_vec
);

  logic [NIRQ-1:0]       s_vec;
  logic [NIRQ-1:0]       edge_vec;
  logic [NIRQ-1:0]       pend;
  logic [NIRQ-1:0]       mask;
  logic [NIRQ-1:0]       mode;
  logic                  gie;
  logic                  wr;
  logic [NIRQ-1:0]       w1c_bits;
  logic [NIRQ-1:0]       set_bits;
  logic [NIRQ-1:0]       ack_bits;
  logic [NIRQ-1:0]       act;
  logic [NIRQ-1:0]       pend_nxt;
  logic [IRQC_VEC_W-1:0] vec_nxt;

  generate
    for (genvar gi = 0; gi < NIRQ; gi++) begin : g_line
      irq_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
      ) u_sync (
        .clk      (clk),
        .reset    (reset),
        .irq_in   (irq_in[gi]),
        .s        (s_vec[gi]),
        .edge_evt (edge_vec[gi])
      );
    end
  endgenerate

  assign wr       = cs & wen;
  assign w1c_bits = (wr && (addr == IRQC_PEND)) ? din[NIRQ-1:0] : '0;
  assign set_bits = (wr && (addr == IRQC_SET))  ? din[NIRQ-1:0] : '0;

  // Ack targets the line already being presented, and only while irq is up
  always_comb begin
    ack_bits = '0;
    for (int i = 0; i < NIRQ; i++) begin
      ack_bits[i] = irq_ack & irq & (irq_vec == IRQC_VEC_W'(i));
    end
  end

  // Level lines track s; edge lines: set beats clear, otherwise hold
  assign pend_nxt = (~mode & s_vec)
                  | (mode & (edge_vec | set_bits | (pend & ~(w1c_bits | ack_bits))));

  assign act = pend & mask;

  always_comb begin
    vec_nxt = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (act[i]) begin
        vec_nxt = IRQC_VEC_W'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend    <= '0;
      mask    <= '0;
      mode    <= '0;
      gie     <= 1'b0;
      irq     <= 1'b0;
      irq_vec <= '0;
    end else begin
      pend <= pend_nxt;
      if (wr && (addr == IRQC_MASK)) begin
        mask <= din[NIRQ-1:0];
      end
      if (wr && (addr == IRQC_MODE)) begin
        mode <= din[NIRQ-1:0];
      end
      if (wr && (addr == IRQC_CTRL)) begin
        gie <= din[0];
      end
      irq     <= gie & (|act);
      irq_vec <= vec_nxt;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      IRQC_PEND: dout[NIRQ-1:0] = pend;
      IRQC_MASK: dout[NIRQ-1:0] = mask;
      IRQC_MODE: dout[NIRQ-1:0] = mode;
      IRQC_VEC: begin
        dout[IRQC_VEC_VALID_BIT]  = irq;
        dout[IRQC_VEC_W-1:0]      = irq_vec;
      end
      IRQC_CTRL: dout[0] = gie;
      default:   dout = '0;
    endcase
  end

endmodule : irq_ctrl
`default_nettype wire
